// File: rtl/select_grant_pipe_if.sv
// Select-to-register-read handshake bundle for the grant pipe.
interface select_grant_pipe_if #(
  parameter int ENCODER_WIDTH = 32,
  parameter int INDEX_WIDTH   = 5
);
  logic                     flush_i;
  logic [ENCODER_WIDTH-1:0] grant_i;
  logic                     ready_i;
  logic                     valid_o;
  logic [INDEX_WIDTH-1:0]   index_o;
  logic [ENCODER_WIDTH-1:0] issued_o;
  logic                     stall_o;
  logic                     error_o;

  // Driver side: select stage plus downstream ready/flush control.
  modport master (
    output flush_i, grant_i, ready_i,
    input  valid_o, index_o, issued_o, stall_o, error_o
  );

  // The grant pipe itself.
  modport slave (
    input  flush_i, grant_i, ready_i,
    output valid_o, index_o, issued_o, stall_o, error_o
  );
endinterface

// File: rtl/select_grant_pipe.sv
// Converts a one-hot select grant into a binary issue-queue index and holds
// it in a 2-entry in-order skid buffer. stall_o is purely registered so the
// select stage never sees a combinational path from ready_i.
module select_grant_pipe #(
  parameter int ENCODER_WIDTH = 32,
  parameter int INDEX_WIDTH   = 5
) (
  input logic                clk,
  input logic                reset,
  select_grant_pipe_if.slave bus
);

  logic [1:0]               count_q, count_d;
  logic [INDEX_WIDTH-1:0]   head_q, head_d;
  logic [INDEX_WIDTH-1:0]   tail_q, tail_d;
  logic                     error_q, error_d;

  logic [ENCODER_WIDTH-1:0] low_hot;
  logic [INDEX_WIDTH-1:0]   new_idx;
  logic                     multi_hot;
  logic                     stall;
  logic                     accept;
  logic                     pop;

  // Isolate the lowest set bit, its position, and flag multi-hot grants.
  always_comb begin
    low_hot   = bus.grant_i & (~bus.grant_i + ENCODER_WIDTH'(1));
    multi_hot = (bus.grant_i & (bus.grant_i - ENCODER_WIDTH'(1))) != '0;
    new_idx   = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = ENCODER_WIDTH - 1; i >= 0; i--) begin
      if (bus.grant_i[i]) new_idx = INDEX_WIDTH'(i);
    end
  end

  assign stall  = (count_q == 2'd2);
  assign accept = (bus.grant_i != '0) && !stall && !bus.flush_i && !reset;
  assign pop    = (count_q != 2'd0) && bus.ready_i && !bus.flush_i;

  assign bus.valid_o  = (count_q != 2'd0);
  assign bus.index_o  = head_q;
  assign bus.stall_o  = stall;
  assign bus.error_o  = error_q;
  assign bus.issued_o = accept ? low_hot : '0;

  // Buffer next state: flush empties; accept/pop shift entries in order.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    error_d = error_q | (accept & multi_hot);
    if (bus.flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_idx;
          else                 tail_d = new_idx;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Accept implies count < 2, so with a pop the head was the only
        // entry and the new one takes its place.
        2'b11:   head_d = new_idx;
        default: ;
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_select_grant_pipe.sv
// Directed scoreboard bench: stimulus pushes expected indices, a monitor
// pops and compares every time the pipe hands an entry downstream.
module tb_select_grant_pipe;
  localparam int EW = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  select_grant_pipe_if #(.ENCODER_WIDTH(EW), .INDEX_WIDTH(IW)) bus();

  select_grant_pipe #(.ENCODER_WIDTH(EW), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handoff must match the oldest expected index.
  always @(negedge clk) begin
    if (!reset && bus.valid_o && bus.ready_i && !bus.flush_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0d required=none", bus.index_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (bus.index_o !== IW'(e)) begin
          errors++;
          $display("FAIL pop_index actual=%0d required=%0d", bus.index_o, e);
        end
      end
    end
  end

  // One cycle of stimulus; same-cycle combinational outputs checked at negedge.
  task automatic cyc(input logic [31:0] g, input logic r, input logic f,
                     input logic [31:0] exp_issued, input logic exp_stall,
                     input int push_idx);
    @(posedge clk); #1;
    bus.grant_i = g; bus.ready_i = r; bus.flush_i = f;
    if (f) exp_q.delete();
    if (push_idx >= 0) exp_q.push_back(push_idx);
    @(negedge clk);
    chk("issued", bus.issued_o, exp_issued);
    chk("stall", {31'd0, bus.stall_o}, {31'd0, exp_stall});
  endtask

  initial begin
    reset = 1'b1;
    bus.grant_i = 32'h1; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("issued_in_reset", bus.issued_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; bus.grant_i = '0;
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_index", {27'd0, bus.index_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("rst_error", {31'd0, bus.error_o}, 32'd0);

    // Single grant, empty buffer, ready downstream.
    cyc(32'h100, 1, 0, 32'h100, 0, 8);
    cyc(32'h0,   1, 0, 32'h0,   0, -1);
    chk("lat_valid", {31'd0, bus.valid_o}, 32'd1);

    // Fill with ready low, third grant refused, drain in order.
    cyc(32'h1, 0, 0, 32'h1, 0, 0);
    cyc(32'h2, 0, 0, 32'h2, 0, 1);
    cyc(32'h4, 0, 0, 32'h0, 1, -1);
    cyc(32'h0, 1, 0, 32'h0, 1, -1);
    cyc(32'h0, 1, 0, 32'h0, 0, -1);
    cyc(32'h0, 0, 0, 32'h0, 0, -1);
    chk("drained_valid", {31'd0, bus.valid_o}, 32'd0);

    // Full buffer popping while grant offered: refused, then accepted.
    cyc(32'h1, 0, 0, 32'h1, 0, 0);
    cyc(32'h2, 0, 0, 32'h2, 0, 1);
    cyc(32'h8, 1, 0, 32'h0, 1, -1);
    cyc(32'h8, 0, 0, 32'h8, 0, 3);
    cyc(32'h0, 1, 0, 32'h0, 1, -1);
    cyc(32'h0, 1, 0, 32'h0, 0, -1);

    // Count 1 with simultaneous pop and top-bit grant.
    cyc(32'h10,        0, 0, 32'h10,        0, 4);
    cyc(32'h8000_0000, 1, 0, 32'h8000_0000, 0, 31);
    cyc(32'h0,         0, 0, 32'h0,         0, -1);
    chk("top_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("top_index", {27'd0, bus.index_o}, 32'd31);
    cyc(32'h0, 1, 0, 32'h0, 0, -1);

    // Multi-hot grant: lowest bit taken, sticky error.
    cyc(32'h6, 1, 0, 32'h2, 0, 1);
    chk("err_before", {31'd0, bus.error_o}, 32'd0);
    cyc(32'h20, 1, 0, 32'h20, 0, 5);
    chk("err_set", {31'd0, bus.error_o}, 32'd1);
    cyc(32'h0, 1, 0, 32'h0, 0, -1);
    chk("err_held", {31'd0, bus.error_o}, 32'd1);

    // Flush with a full buffer and a pending grant.
    cyc(32'h1,  0, 0, 32'h1, 0, 0);
    cyc(32'h2,  0, 0, 32'h2, 0, 1);
    cyc(32'h10, 1, 1, 32'h0, 1, -1);
    cyc(32'h0,  0, 0, 32'h0, 0, -1);
    chk("flush_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("flush_err_kept", {31'd0, bus.error_o}, 32'd1);

    // Reset arriving with the buffer full.
    cyc(32'h1, 0, 0, 32'h1, 0, 0);
    cyc(32'h2, 0, 0, 32'h2, 0, 1);
    @(posedge clk); #1;
    reset = 1'b1; bus.grant_i = 32'h4; bus.ready_i = 1'b1; bus.flush_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_issued", bus.issued_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; bus.grant_i = '0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("midrst_index", {27'd0, bus.index_o}, 32'd0);
    chk("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("midrst_error", {31'd0, bus.error_o}, 32'd0);

    // Normal operation resumes after reset.
    cyc(32'h400, 1, 0, 32'h400, 0, 10);
    cyc(32'h0,   1, 0, 32'h0,   0, -1);

    // Bounded drain: all expected entries must have come out.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
